// File: rtl/wallace_colserial_mult_if.sv
// Operand and result valid/ready bundle for the column-serial multiplier.
// The master side is the requester/consumer; the slave side is the multiplier.
interface wallace_colserial_mult_if #(
    parameter int N = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   product;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/wallace_colserial_mult.sv
// Unsigned N x N multiplier that reduces one product column per clock with a
// single shared column compressor, walking from the LSB column upward.
module wallace_colserial_mult #(
    parameter int N  = 8,
    parameter int CW = $clog2(N) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    wallace_colserial_mult_if.slave  bus,
    input  logic                     abort,
    output logic                     busy,
    output logic [$clog2(2*N)-1:0]   col_idx
);

    localparam int KW = $clog2(2*N);
    localparam int VW = CW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state;
    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;
    logic [CW-1:0]  carry;
    logic [2*N-1:0] prod_reg;
    logic [VW-1:0]  col_sum;

    // Column compressor: count the partial products a[i]&b[j] with i+j equal
    // to the current column, on top of the carry left by the column below.
    always_comb begin
        col_sum = {1'b0, carry};
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (KW'(i + j) == col_idx) begin
                    col_sum = col_sum + VW'(a_reg[i] & b_reg[j]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= '0;
            prod_reg <= '0;
            col_idx  <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!abort && bus.in_valid) begin
                        a_reg    <= bus.a;
                        b_reg    <= bus.b;
                        carry    <= '0;
                        prod_reg <= '0;
                        col_idx  <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        carry   <= '0;
                        col_idx <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        prod_reg[col_idx] <= col_sum[0];
                        carry             <= col_sum[CW:1];
                        // The top column wraps col_idx back to zero on exit.
                        col_idx           <= col_idx + KW'(1);
                        if (col_idx == KW'(2*N - 1)) begin
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (abort) begin
                        carry   <= '0;
                        col_idx <= '0;
                        state   <= IDLE;
                    end else if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.product   = prod_reg;

endmodule

// File: tb/tb_wallace_colserial_mult.sv
// Scoreboard bench for wallace_colserial_mult: directed handshake/abort/reset
// cases plus random sweeps on an N=8 and an N=4 instance.
module tb_wallace_colserial_mult;

    logic clk = 1'b0;
    logic rst_n;
    logic rst4_n;
    logic abort8;
    logic abort4;
    logic busy8;
    logic busy4;
    logic [3:0] col8;
    logic [2:0] col4;

    int checks = 0;
    int fails  = 0;
    int cycle  = 0;
    bit done4  = 0;

    logic [31:0] q8[$];
    logic [31:0] q4[$];
    int accept8 = 0;
    int accept4 = 0;
    bit prev8 = 0;
    bit prev4 = 0;

    wallace_colserial_mult_if #(.N(8)) bus8 ();
    wallace_colserial_mult_if #(.N(4)) bus4 ();

    wallace_colserial_mult #(.N(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus8),
        .abort   (abort8),
        .busy    (busy8),
        .col_idx (col8)
    );

    wallace_colserial_mult #(.N(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst4_n),
        .bus     (bus4),
        .abort   (abort4),
        .busy    (busy4),
        .col_idx (col4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Scoreboard monitors sample mid-cycle, when the next edge's inputs are stable.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus8.out_valid && !prev8) begin
                checkOutput("latency8", 32'(cycle - accept8), 32'd16);
                checkOutput("final_carry8", 32'(dut.carry), 32'd0);
            end
            prev8 = bus8.out_valid;
            if (bus8.out_valid && bus8.out_ready && !abort8) begin
                if (q8.size() == 0) checkOutput("sb_empty8", 32'(bus8.product), 32'hdead);
                else checkOutput("product8", 32'(bus8.product), q8.pop_front());
            end
            if (bus8.in_valid && bus8.in_ready && !abort8) begin
                q8.push_back(32'(bus8.a) * 32'(bus8.b));
                accept8 = cycle + 1;
            end
        end else begin
            prev8 = 0;
        end
    end

    always @(negedge clk) begin
        if (rst4_n) begin
            if (bus4.out_valid && !prev4) begin
                checkOutput("latency4", 32'(cycle - accept4), 32'd8);
                checkOutput("final_carry4", 32'(dut4.carry), 32'd0);
            end
            prev4 = bus4.out_valid;
            if (bus4.out_valid && bus4.out_ready && !abort4) begin
                if (q4.size() == 0) checkOutput("sb_empty4", 32'(bus4.product), 32'hdead);
                else checkOutput("product4", 32'(bus4.product), q4.pop_front());
            end
            if (bus4.in_valid && bus4.in_ready && !abort4) begin
                q4.push_back(32'(bus4.a) * 32'(bus4.b));
                accept4 = cycle + 1;
            end
        end else begin
            prev4 = 0;
        end
    end

    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
        bus8.a = av;
        bus8.b = bv;
        bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic waitValid(input int budget);
        bit seen = 0;
        for (int c = 0; c < budget; c++) begin
            if (bus8.out_valid) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) checkOutput("timeout_valid", 32'(bus8.out_valid), 32'd1);
    endtask

    task automatic waitCol(input logic [3:0] col);
        bit seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (col8 == col) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) checkOutput("timeout_col", 32'(col8), 32'(col));
    endtask

    task automatic runOp(input logic [7:0] av, input logic [7:0] bv, input bit rnd);
        bit done = 0;
        applyStimulus(av, bv);
        for (int c = 0; c < 200; c++) begin
            if (bus8.out_valid && bus8.out_ready) begin
                @(posedge clk); #1;
                done = 1;
                break;
            end
            @(posedge clk); #1;
            if (rnd) bus8.out_ready = 1'($urandom_range(0, 1));
        end
        if (!done) checkOutput("timeout_op", 32'(bus8.out_valid), 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(bus8.in_ready), 32'd1);
        checkOutput({tag, "_out_valid"}, 32'(bus8.out_valid), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy8), 32'd0);
        checkOutput({tag, "_product"}, 32'(bus8.product), 32'd0);
        checkOutput({tag, "_col_idx"}, 32'(col8), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        abort8 = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        bus8.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        runOp(8'hFF, 8'hFF, 0);
        checkOutput("idle_after_done", 32'(bus8.in_ready), 32'd1);
        runOp(8'h00, 8'hA5, 0);
        runOp(8'h01, 8'hA5, 0);

        // Consumer stalls: result must hold and new requests must be ignored.
        bus8.out_ready = 1'b0;
        applyStimulus(8'h0D, 8'h0B);
        waitValid(40);
        for (int c = 0; c < 5; c++) begin
            checkOutput("hold_product", 32'(bus8.product), 32'h008F);
            checkOutput("hold_in_ready", 32'(bus8.in_ready), 32'd0);
            bus8.in_valid = 1'(c % 2);
            bus8.a = 8'h77;
            @(posedge clk); #1;
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("hold_release", 32'(bus8.in_ready), 32'd1);

        // Operands wiggle every cycle during RUN; only the captured pair counts.
        bus8.a = 8'h37;
        bus8.b = 8'h49;
        bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 40; c++) begin
            if (bus8.out_valid) break;
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
            @(posedge clk); #1;
        end
        bus8.in_valid = 1'b0;
        @(posedge clk); #1;

        // Abort in IDLE wins over in_valid.
        bus8.a = 8'h05;
        bus8.b = 8'h05;
        bus8.in_valid = 1'b1;
        abort8 = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        abort8 = 1'b0;
        checkOutput("idle_abort_busy", 32'(busy8), 32'd0);
        checkOutput("idle_abort_ready", 32'(bus8.in_ready), 32'd1);

        applyStimulus(8'h12, 8'h34);
        waitCol(4'd6);
        abort8 = 1'b1;
        @(posedge clk); #1;
        abort8 = 1'b0;
        q8.delete();
        checkOutput("abort_out_valid", 32'(bus8.out_valid), 32'd0);
        checkOutput("abort_in_ready", 32'(bus8.in_ready), 32'd1);
        checkOutput("abort_col_idx", 32'(col8), 32'd0);
        checkOutput("abort_busy", 32'(busy8), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("abort_no_valid", 32'(bus8.out_valid), 32'd0);

        applyStimulus(8'h56, 8'h78);
        waitCol(4'd9);
        #2 rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        q8.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        runOp(8'd200, 8'd3, 0);

        // Abort in DONE wins over out_ready.
        bus8.out_ready = 1'b0;
        applyStimulus(8'h09, 8'h09);
        waitValid(40);
        bus8.out_ready = 1'b1;
        abort8 = 1'b1;
        @(posedge clk); #1;
        abort8 = 1'b0;
        q8.delete();
        checkOutput("done_abort_valid", 32'(bus8.out_valid), 32'd0);
        checkOutput("done_abort_ready", 32'(bus8.in_ready), 32'd1);

        for (int n = 0; n < 1500; n++) begin
            runOp(8'($urandom), 8'($urandom), 1);
        end
        bus8.out_ready = 1'b1;

        for (int c = 0; c < 60000 && !done4; c++) @(posedge clk);
        checkOutput("n4_finished", 32'(done4), 32'd1);
        checkOutput("sb_drained8", 32'(q8.size()), 32'd0);
        checkOutput("sb_drained4", 32'(q4.size()), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        rst4_n = 1'b0;
        abort4 = 1'b0;
        bus4.in_valid = 1'b0;
        bus4.a = '0;
        bus4.b = '0;
        bus4.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst4_n = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            bit done = 0;
            bus4.a = 4'($urandom);
            bus4.b = 4'($urandom);
            bus4.in_valid = 1'b1;
            @(posedge clk); #1;
            bus4.in_valid = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (bus4.out_valid && bus4.out_ready) begin
                    @(posedge clk); #1;
                    done = 1;
                    break;
                end
                @(posedge clk); #1;
                bus4.out_ready = 1'($urandom_range(0, 1));
            end
            if (!done) checkOutput("timeout_op4", 32'(bus4.out_valid), 32'd1);
        end
        done4 = 1;
    end

endmodule
